sdram_axi_burst_split: RTL and testbench
========================================

// Module: sdram_axi_burst_split
// PURPOSE
// - AXI4 burst splitter placed directly upstream of the SDRAM AXI4 slave (s_* from CPU/xbar, m_* to SDRAM port).
// - Breaks INCR bursts longer than MAX_BEATS into back-to-back sub-bursts, regenerates m_wlast per sub-burst.
// - Reassembles responses: one merged B per write; s_rlast only on final beat of the original burst.
// - One outstanding transaction per direction; read and write paths independent.
// PARAMETERS
// - MAX_BEATS   8   max beats per downstream sub-burst (power of 2, 1..256)
// - SDRAM_COL_W 9   column width; row span = 2^(SDRAM_COL_W+2) bytes (used only with SDRAM_SPLIT_BOUNDARY_EN)
// PORTS
// - clk_i  in 1  clock
// - rst_i  in 1  reset, asynchronous, active-high
// - s_aw{valid_i,ready_o,addr_i[31:0],id_i[3:0],len_i[7:0],burst_i[1:0]}  upstream AW
// - s_w{valid_i,ready_o,data_i[31:0],strb_i[3:0],last_i}  upstream W
// - s_b{valid_o,ready_i,resp_o[1:0],id_o[3:0]}  upstream B
// - s_ar{valid_i,ready_o,addr_i[31:0],id_i[3:0],len_i[7:0],burst_i[1:0]}  upstream AR
// - s_r{valid_o,ready_i,data_o[31:0],resp_o[1:0],id_o[3:0],last_o}  upstream R
// - m_aw*/m_w*/m_b*/m_ar*/m_r*  same widths, opposite directions  downstream to SDRAM AXI slave
// BEHAVIOUR
// - Reset: all *valid_o=0, s_awready_o=s_arready_o=0 while rst_i high; FSMs -> IDLE; counters, merged resp=0.
// - Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> (W_ADDR if beats remain | W_BACK) -> W_IDLE.
//   - W_IDLE: s_awready_o=1; on handshake latch addr/id/burst, remaining=len+1, bresp_acc=OKAY.
//   - W_ADDR: m_awvalid_o=1 (registered), m_awlen=sub-1; sub=min(remaining,MAX_BEATS); m_awid=latched id.
//   - W_DATA: s_w passes combinationally to m_w (valid/ready/data/strb); m_wlast_o=(beat_cnt==sub-1); s_wlast_i ignored.
//   - W_RESP: m_bready_o=1; bresp_acc=max(bresp_acc,m_bresp_i) (SLVERR/DECERR sticky); addr+=4*sub; remaining-=sub.
//   - W_BACK: s_bvalid_o=1, s_bresp_o=bresp_acc, s_bid_o=latched id; held until s_bready_i.
// - Read FSM: R_IDLE -> R_ADDR -> R_DATA -> (R_ADDR if beats remain | R_IDLE).
//   - R_DATA: m_r passes combinationally to s_r; s_rid_o=latched id; s_rlast_o=m_rlast_i & (remaining==sub).
//   - m_rresp_i forwarded per beat unchanged; leave R_DATA on m_rlast_i handshake.
// - Latency: +1 cycle per sub-burst address phase (registered m_ax); zero added latency on data beats.
// - Non-INCR (FIXED/WRAP) or len+1<=MAX_BEATS: forwarded as a single burst, len/addr unchanged.
// - Arithmetic: remaining 9 bits (max 256); addr increments 32-bit, wraps modulo 2^32 without error.
// - s_wvalid_i before AW accepted: s_wready_o=0 (W held off until W_DATA).
// - B/R backpressure: never drop beats; m_rready_o=s_rready_i, m_bready only in W_RESP.
// - Simultaneous AW and AR accept: both accepted same cycle; paths share no state.
// - Reset mid-burst: transaction abandoned, no further beats or responses issued.
// CONFIGURATION
// - SDRAM_SPLIT_BOUNDARY_EN defined: sub=min(remaining,MAX_BEATS,beats_to_row_end) for INCR,
//   beats_to_row_end=(2^(SDRAM_COL_W+2)-(addr mod 2^(SDRAM_COL_W+2)))/4; no sub-burst crosses a row.
// - Undefined: row boundaries ignored; only MAX_BEATS limits sub-burst length.
// TESTING
// - INCR write len=19 @0x8000_0000, MAX_BEATS=8 -> m_aw len 7,7,3 @0x..00,0x..20,0x..40; m_wlast on beats 8,16,20; one s_b OKAY.
// - INCR read len=19, id=5 -> 3 m_ar; 20 s_r beats id=5, s_rlast_o only on beat 20, data order preserved.
// - Write len=15, m_bresp OKAY then SLVERR -> single s_bresp_o=2'b10 after second m_b.
// - FIXED read len=15 -> single m_ar len=15 burst=FIXED, unchanged passthrough.
// - With SDRAM_SPLIT_BOUNDARY_EN, INCR read len=3 @0x0000_07F8 -> m_ar len 1 @0x7F8 then len 1 @0x800.
// - Assert rst_i during beat 10 of len=19 write -> all valids 0 immediately; next AW accepted cleanly, OKAY.

Source files
------------

// File: rtl/sdram_axi_burst_split.sv
// AXI4 INCR burst splitter in front of the SDRAM slave: +1 cycle per sub-burst address, data beats pass straight through with end-to-end valid/ready.
// Optional macro SDRAM_SPLIT_BOUNDARY_EN additionally ends every INCR sub-burst at an SDRAM row boundary.
module sdram_axi_burst_split #(
    parameter int MAX_BEATS   = 8,
    parameter int SDRAM_COL_W = 9
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_awvalid_i,
    output logic        s_awready_o,
    input  logic [31:0] s_awaddr_i,
    input  logic [3:0]  s_awid_i,
    input  logic [7:0]  s_awlen_i,
    input  logic [1:0]  s_awburst_i,
    input  logic        s_wvalid_i,
    output logic        s_wready_o,
    input  logic [31:0] s_wdata_i,
    input  logic [3:0]  s_wstrb_i,
    input  logic        s_wlast_i,
    output logic        s_bvalid_o,
    input  logic        s_bready_i,
    output logic [1:0]  s_bresp_o,
    output logic [3:0]  s_bid_o,
    input  logic        s_arvalid_i,
    output logic        s_arready_o,
    input  logic [31:0] s_araddr_i,
    input  logic [3:0]  s_arid_i,
    input  logic [7:0]  s_arlen_i,
    input  logic [1:0]  s_arburst_i,
    output logic        s_rvalid_o,
    input  logic        s_rready_i,
    output logic [31:0] s_rdata_o,
    output logic [1:0]  s_rresp_o,
    output logic [3:0]  s_rid_o,
    output logic        s_rlast_o,
    output logic        m_awvalid_o,
    input  logic        m_awready_i,
    output logic [31:0] m_awaddr_o,
    output logic [3:0]  m_awid_o,
    output logic [7:0]  m_awlen_o,
    output logic [1:0]  m_awburst_o,
    output logic        m_wvalid_o,
    input  logic        m_wready_i,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    output logic        m_wlast_o,
    input  logic        m_bvalid_i,
    output logic        m_bready_o,
    input  logic [1:0]  m_bresp_i,
    input  logic [3:0]  m_bid_i,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    output logic [31:0] m_araddr_o,
    output logic [3:0]  m_arid_o,
    output logic [7:0]  m_arlen_o,
    output logic [1:0]  m_arburst_o,
    input  logic        m_rvalid_i,
    output logic        m_rready_o,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    input  logic [3:0]  m_rid_i,
    input  logic        m_rlast_i
);
    localparam int ROW_W = SDRAM_COL_W + 2;
`ifdef SDRAM_SPLIT_BOUNDARY_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    // Beats left before the end of the current SDRAM row, clamped to 1..256.
    function automatic logic [8:0] f_rowlim(input logic [ROW_W-1:0] off);
        logic [31:0] b;
        b = ((32'd1 << ROW_W) - 32'(off)) >> 2;
        if (b > 32'd256) b = 32'd256;
        if (b == 32'd0)  b = 32'd1;
        return b[8:0];
    endfunction

    function automatic logic [8:0] f_sub(input logic [8:0] rem, input logic [1:0] burst,
                                         input logic [8:0] lim);
        logic [8:0] s;
        s = rem;
        if (burst == 2'b01) begin
            if (s > 9'(MAX_BEATS)) s = 9'(MAX_BEATS);
            if (BOUND_EN && (s > lim)) s = lim;
        end
        return s;
    endfunction

    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_BACK} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t     r_wstate;
    logic        r_awready, r_awvalid, r_bready, r_bvalid;
    logic [31:0] r_awaddr;
    logic [3:0]  r_awid;
    logic [7:0]  r_awlen;
    logic [1:0]  r_awburst, r_bresp;
    logic [8:0]  r_wrem, r_wsub, r_wbeat;

    rstate_t     r_rstate;
    logic        r_arready, r_arvalid;
    logic [31:0] r_araddr;
    logic [3:0]  r_arid;
    logic [7:0]  r_arlen;
    logic [1:0]  r_arburst;
    logic [8:0]  r_rrem, r_rsub;

    logic        w_in_wdata, w_in_rdata, w_wlast, w_unused;
    logic [8:0]  w_aw_sub, w_wrem_nxt, w_wsub_nxt, w_ar_sub, w_rrem_nxt, w_rsub_nxt;
    logic [31:0] w_waddr_nxt, w_raddr_nxt;

    assign w_aw_sub    = f_sub({1'b0, s_awlen_i} + 9'd1, s_awburst_i, f_rowlim(s_awaddr_i[ROW_W-1:0]));
    assign w_wrem_nxt  = r_wrem - r_wsub;
    assign w_waddr_nxt = r_awaddr + {21'd0, r_wsub, 2'b00};
    assign w_wsub_nxt  = f_sub(w_wrem_nxt, r_awburst, f_rowlim(w_waddr_nxt[ROW_W-1:0]));
    assign w_ar_sub    = f_sub({1'b0, s_arlen_i} + 9'd1, s_arburst_i, f_rowlim(s_araddr_i[ROW_W-1:0]));
    assign w_rrem_nxt  = r_rrem - r_rsub;
    assign w_raddr_nxt = r_araddr + {21'd0, r_rsub, 2'b00};
    assign w_rsub_nxt  = f_sub(w_rrem_nxt, r_arburst, f_rowlim(w_raddr_nxt[ROW_W-1:0]));

    assign w_in_wdata = (r_wstate == W_DATA);
    assign w_wlast    = w_in_wdata && (r_wbeat == r_wsub - 9'd1);
    assign w_in_rdata = (r_rstate == R_DATA);
    // Upstream WLAST and downstream IDs are regenerated locally, so they are not consumed.
    assign w_unused   = ^{s_wlast_i, m_bid_i, m_rid_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_awvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_awid    <= '0;
            r_awlen   <= '0;
            r_awburst <= '0;
            r_bresp   <= '0;
            r_wrem    <= '0;
            r_wsub    <= '0;
            r_wbeat   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (r_awready && s_awvalid_i) begin
                        r_awready <= 1'b0;
                        r_awaddr  <= s_awaddr_i;
                        r_awid    <= s_awid_i;
                        r_awburst <= s_awburst_i;
                        r_wrem    <= {1'b0, s_awlen_i} + 9'd1;
                        r_wsub    <= w_aw_sub;
                        r_awlen   <= 8'(w_aw_sub - 9'd1);
                        r_awvalid <= 1'b1;
                        r_bresp   <= 2'b00;
                        r_wstate  <= W_ADDR;
                    end
                end
                W_ADDR: if (m_awready_i) begin
                    r_awvalid <= 1'b0;
                    r_wbeat   <= '0;
                    r_wstate  <= W_DATA;
                end
                W_DATA: if (s_wvalid_i && m_wready_i) begin
                    r_wbeat <= r_wbeat + 9'd1;
                    if (w_wlast) begin
                        r_bready <= 1'b1;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: if (m_bvalid_i) begin
                    r_bready <= 1'b0;
                    // Numeric max keeps SLVERR/DECERR sticky across sub-bursts.
                    if (m_bresp_i > r_bresp) r_bresp <= m_bresp_i;
                    r_awaddr <= w_waddr_nxt;
                    r_wrem   <= w_wrem_nxt;
                    if (w_wrem_nxt != 9'd0) begin
                        r_wsub    <= w_wsub_nxt;
                        r_awlen   <= 8'(w_wsub_nxt - 9'd1);
                        r_awvalid <= 1'b1;
                        r_wstate  <= W_ADDR;
                    end else begin
                        r_bvalid <= 1'b1;
                        r_wstate <= W_BACK;
                    end
                end
                W_BACK: if (s_bready_i) begin
                    r_bvalid <= 1'b0;
                    r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arid    <= '0;
            r_arlen   <= '0;
            r_arburst <= '0;
            r_rrem    <= '0;
            r_rsub    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (r_arready && s_arvalid_i) begin
                        r_arready <= 1'b0;
                        r_araddr  <= s_araddr_i;
                        r_arid    <= s_arid_i;
                        r_arburst <= s_arburst_i;
                        r_rrem    <= {1'b0, s_arlen_i} + 9'd1;
                        r_rsub    <= w_ar_sub;
                        r_arlen   <= 8'(w_ar_sub - 9'd1);
                        r_arvalid <= 1'b1;
                        r_rstate  <= R_ADDR;
                    end
                end
                R_ADDR: if (m_arready_i) begin
                    r_arvalid <= 1'b0;
                    r_rstate  <= R_DATA;
                end
                R_DATA: if (m_rvalid_i && s_rready_i && m_rlast_i) begin
                    r_araddr <= w_raddr_nxt;
                    r_rrem   <= w_rrem_nxt;
                    if (w_rrem_nxt != 9'd0) begin
                        r_rsub    <= w_rsub_nxt;
                        r_arlen   <= 8'(w_rsub_nxt - 9'd1);
                        r_arvalid <= 1'b1;
                        r_rstate  <= R_ADDR;
                    end else begin
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_awready_o = r_awready;
    assign m_awvalid_o = r_awvalid;
    assign m_awaddr_o  = r_awaddr;
    assign m_awid_o    = r_awid;
    assign m_awlen_o   = r_awlen;
    assign m_awburst_o = r_awburst;
    assign m_wvalid_o  = w_in_wdata && s_wvalid_i;
    assign s_wready_o  = w_in_wdata && m_wready_i;
    assign m_wdata_o   = s_wdata_i;
    assign m_wstrb_o   = s_wstrb_i;
    assign m_wlast_o   = w_wlast;
    assign m_bready_o  = r_bready;
    assign s_bvalid_o  = r_bvalid;
    assign s_bresp_o   = r_bresp;
    assign s_bid_o     = r_awid;

    assign s_arready_o = r_arready;
    assign m_arvalid_o = r_arvalid;
    assign m_araddr_o  = r_araddr;
    assign m_arid_o    = r_arid;
    assign m_arlen_o   = r_arlen;
    assign m_arburst_o = r_arburst;
    assign s_rvalid_o  = w_in_rdata && m_rvalid_i;
    assign m_rready_o  = w_in_rdata && s_rready_i;
    assign s_rdata_o   = m_rdata_i;
    assign s_rresp_o   = m_rresp_i;
    assign s_rid_o     = r_arid;
    assign s_rlast_o   = w_in_rdata && m_rlast_i && (r_rrem == r_rsub);
endmodule

// File: tb/tb_sdram_axi_burst_split.sv
// Directed bench for sdram_axi_burst_split: table of bursts with hand-computed sub-burst splits,
// plus simultaneous AW/AR acceptance and reset in the middle of a write.
module tb_sdram_axi_burst_split;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        s_awvalid_i = 0, s_awready_o;
    logic [31:0] s_awaddr_i = 0;
    logic [3:0]  s_awid_i = 0;
    logic [7:0]  s_awlen_i = 0;
    logic [1:0]  s_awburst_i = 0;
    logic        s_wvalid_i = 0, s_wready_o;
    logic [31:0] s_wdata_i = 0;
    logic [3:0]  s_wstrb_i = 0;
    logic        s_wlast_i = 0;
    logic        s_bvalid_o, s_bready_i = 0;
    logic [1:0]  s_bresp_o;
    logic [3:0]  s_bid_o;
    logic        s_arvalid_i = 0, s_arready_o;
    logic [31:0] s_araddr_i = 0;
    logic [3:0]  s_arid_i = 0;
    logic [7:0]  s_arlen_i = 0;
    logic [1:0]  s_arburst_i = 0;
    logic        s_rvalid_o, s_rready_i = 0;
    logic [31:0] s_rdata_o;
    logic [1:0]  s_rresp_o;
    logic [3:0]  s_rid_o;
    logic        s_rlast_o;
    logic        m_awvalid_o, m_awready_i = 0;
    logic [31:0] m_awaddr_o;
    logic [3:0]  m_awid_o;
    logic [7:0]  m_awlen_o;
    logic [1:0]  m_awburst_o;
    logic        m_wvalid_o, m_wready_i = 0;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_wlast_o;
    logic        m_bvalid_i = 0, m_bready_o;
    logic [1:0]  m_bresp_i = 0;
    logic [3:0]  m_bid_i = 0;
    logic        m_arvalid_o, m_arready_i = 0;
    logic [31:0] m_araddr_o;
    logic [3:0]  m_arid_o;
    logic [7:0]  m_arlen_o;
    logic [1:0]  m_arburst_o;
    logic        m_rvalid_i = 0, m_rready_o;
    logic [31:0] m_rdata_i = 0;
    logic [1:0]  m_rresp_i = 0;
    logic [3:0]  m_rid_i = 0;
    logic        m_rlast_i = 0;

    sdram_axi_burst_split dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i),
        .s_awid_i(s_awid_i), .s_awlen_i(s_awlen_i), .s_awburst_i(s_awburst_i),
        .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wdata_i(s_wdata_i),
        .s_wstrb_i(s_wstrb_i), .s_wlast_i(s_wlast_i),
        .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o), .s_bid_o(s_bid_o),
        .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
        .s_arid_i(s_arid_i), .s_arlen_i(s_arlen_i), .s_arburst_i(s_arburst_i),
        .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o),
        .s_rresp_o(s_rresp_o), .s_rid_o(s_rid_o), .s_rlast_o(s_rlast_o),
        .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o),
        .m_awid_o(m_awid_o), .m_awlen_o(m_awlen_o), .m_awburst_o(m_awburst_o),
        .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wdata_o(m_wdata_o),
        .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
        .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i), .m_bid_i(m_bid_i),
        .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
        .m_arid_o(m_arid_o), .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
        .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i),
        .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i), .m_rlast_i(m_rlast_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit              wr;
        logic [31:0]     addr;
        logic [3:0]      id;
        logic [7:0]      len;
        logic [1:0]      burst;
        int              err_sub;
        logic [1:0]      err_resp;
        int              n_sub;
        logic [3:0][7:0] e_len;
        logic [3:0][31:0] e_addr;
        logic [1:0]      e_resp;
    } vec_t;

    vec_t vecs[10];
    int   n_chk = 0;
    int   n_fail = 0;
    time  t_aw, t_ar;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [3:0] id,
                                input logic [7:0] len, input logic [1:0] burst, input int err_sub,
                                input logic [1:0] err_resp, input int n, input logic [7:0] l0,
                                input logic [7:0] l1, input logic [7:0] l2, input logic [31:0] a0,
                                input logic [31:0] a1, input logic [31:0] a2, input logic [1:0] eresp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.id = id; v.len = len; v.burst = burst;
        v.err_sub = err_sub; v.err_resp = err_resp; v.n_sub = n; v.e_resp = eresp;
        v.e_len = '0; v.e_addr = '0;
        v.e_len[0] = l0; v.e_len[1] = l1; v.e_len[2] = l2;
        v.e_addr[0] = a0; v.e_addr[1] = a1; v.e_addr[2] = a2;
        return v;
    endfunction

    task automatic check_all_idle(input string tag);
        chk({tag, "_s_awready"}, 32'(s_awready_o), 32'd0);
        chk({tag, "_s_arready"}, 32'(s_arready_o), 32'd0);
        chk({tag, "_m_awvalid"}, 32'(m_awvalid_o), 32'd0);
        chk({tag, "_m_wvalid"},  32'(m_wvalid_o),  32'd0);
        chk({tag, "_s_wready"},  32'(s_wready_o),  32'd0);
        chk({tag, "_m_bready"},  32'(m_bready_o),  32'd0);
        chk({tag, "_s_bvalid"},  32'(s_bvalid_o),  32'd0);
        chk({tag, "_m_arvalid"}, 32'(m_arvalid_o), 32'd0);
        chk({tag, "_s_rvalid"},  32'(s_rvalid_o),  32'd0);
    endtask

    task automatic run_write(input vec_t v, input int abort_at);
        int  nbeats, nsub, wsent, in_sub, dbursts, bdone;
        bit  aw_done, done;
        nbeats = int'(v.len) + 1;
        nsub = 0; wsent = 0; in_sub = 0; dbursts = 0; bdone = 0; aw_done = 0; done = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk_i);
            s_awvalid_i = !aw_done;
            s_awaddr_i = v.addr; s_awid_i = v.id; s_awlen_i = v.len; s_awburst_i = v.burst;
            s_wvalid_i = (wsent < nbeats) && (cyc % 5 != 3);
            s_wdata_i = {8'hA5, 4'h0, v.id, 16'(wsent)};
            s_wstrb_i = 4'(wsent) | 4'h1;
            s_wlast_i = (wsent == nbeats - 1);
            m_awready_i = (cyc % 2 == 0);
            m_wready_i = (cyc % 4 != 1);
            m_bvalid_i = (dbursts > bdone);
            m_bresp_i = (bdone == v.err_sub) ? v.err_resp : 2'b00;
            s_bready_i = (cyc % 3 != 0);
            #1;
            if (wsent == abort_at) begin
                rst_i = 1'b1;
                #1;
                check_all_idle("abort");
                return;
            end
            if (!aw_done) chk("w_held_before_aw", 32'(s_wready_o), 32'd0);
            if (s_awvalid_i && s_awready_o) begin
                aw_done = 1; t_aw = $time;
            end
            if (m_awvalid_o && m_awready_i) begin
                if (nsub < v.n_sub) begin
                    chk("m_awaddr", m_awaddr_o, v.e_addr[nsub]);
                    chk("m_awlen", 32'(m_awlen_o), 32'(v.e_len[nsub]));
                    chk("m_awid", 32'(m_awid_o), 32'(v.id));
                    chk("m_awburst", 32'(m_awburst_o), 32'(v.burst));
                end else begin
                    chk("extra_m_aw", 32'(nsub), 32'(v.n_sub - 1));
                end
                nsub++;
            end
            if (s_wvalid_i && s_wready_o) begin
                chk("m_wvalid", 32'(m_wvalid_o), 32'd1);
                chk("m_wdata", m_wdata_o, s_wdata_i);
                chk("m_wstrb", 32'(m_wstrb_o), 32'(s_wstrb_i));
                chk("m_wlast", 32'(m_wlast_o),
                    32'(dbursts < 4 && in_sub == int'(v.e_len[dbursts & 3])));
                wsent++;
                if (dbursts < 4 && in_sub == int'(v.e_len[dbursts & 3])) begin
                    dbursts++; in_sub = 0;
                end else begin
                    in_sub++;
                end
            end
            if (m_bvalid_i && m_bready_o) bdone++;
            if (s_bvalid_o && s_bready_i) begin
                chk("s_bresp", 32'(s_bresp_o), 32'(v.e_resp));
                chk("s_bid", 32'(s_bid_o), 32'(v.id));
                chk("wr_sub_count", 32'(nsub), 32'(v.n_sub));
                chk("wr_beats", 32'(wsent), 32'(nbeats));
                chk("wr_m_b_count", 32'(bdone), 32'(v.n_sub));
                done = 1;
            end
        end
        chk("wr_done_in_budget", 32'(done), 32'd1);
        @(negedge clk_i);
        s_awvalid_i = 0; s_wvalid_i = 0; m_awready_i = 0; m_wready_i = 0;
        m_bvalid_i = 0; s_bready_i = 0;
    endtask

    task automatic run_read(input vec_t v);
        int nbeats, nsub, rcnt, in_sub, served;
        bit ar_done, done;
        nbeats = int'(v.len) + 1;
        nsub = 0; rcnt = 0; in_sub = 0; served = 0; ar_done = 0; done = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk_i);
            s_arvalid_i = !ar_done;
            s_araddr_i = v.addr; s_arid_i = v.id; s_arlen_i = v.len; s_arburst_i = v.burst;
            m_arready_i = (cyc % 3 != 1);
            m_rvalid_i = (served < nsub) && (cyc % 4 != 2);
            m_rdata_i = 32'hD000_0000 + 32'(rcnt);
            m_rlast_i = (served < 4) && (in_sub == int'(v.e_len[served & 3]));
            m_rresp_i = (rcnt == 3) ? 2'b10 : 2'b00;
            m_rid_i = 4'hF;
            s_rready_i = (cyc % 3 != 2);
            #1;
            if (s_arvalid_i && s_arready_o) begin
                ar_done = 1; t_ar = $time;
            end
            if (m_arvalid_o && m_arready_i) begin
                if (nsub < v.n_sub) begin
                    chk("m_araddr", m_araddr_o, v.e_addr[nsub]);
                    chk("m_arlen", 32'(m_arlen_o), 32'(v.e_len[nsub]));
                    chk("m_arid", 32'(m_arid_o), 32'(v.id));
                    chk("m_arburst", 32'(m_arburst_o), 32'(v.burst));
                end else begin
                    chk("extra_m_ar", 32'(nsub), 32'(v.n_sub - 1));
                end
                nsub++;
            end
            if (s_rvalid_o && s_rready_i) begin
                chk("m_rready", 32'(m_rready_o), 32'd1);
                chk("s_rdata", s_rdata_o, 32'hD000_0000 + 32'(rcnt));
                chk("s_rid", 32'(s_rid_o), 32'(v.id));
                chk("s_rresp", 32'(s_rresp_o), (rcnt == 3) ? 32'd2 : 32'd0);
                chk("s_rlast", 32'(s_rlast_o), 32'(rcnt == nbeats - 1));
                rcnt++;
                if (m_rlast_i) begin
                    served++; in_sub = 0;
                end else begin
                    in_sub++;
                end
                if (rcnt == nbeats) begin
                    chk("rd_sub_count", 32'(nsub), 32'(v.n_sub));
                    done = 1;
                end
            end
        end
        chk("rd_done_in_budget", 32'(done), 32'd1);
        @(negedge clk_i);
        s_arvalid_i = 0; m_arready_i = 1; m_rvalid_i = 0; m_rlast_i = 0; s_rready_i = 0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rd_no_extra_ar", 32'(m_arvalid_o), 32'd0);
        m_arready_i = 0;
    endtask

    initial begin
        vecs[0] = mk(1, 32'h8000_0000, 4'd3, 8'd19, 2'b01, -1, 2'b00, 3, 8'd7, 8'd7, 8'd3,
                     32'h8000_0000, 32'h8000_0020, 32'h8000_0040, 2'b00);
        vecs[1] = mk(0, 32'h1000_0100, 4'd5, 8'd19, 2'b01, -1, 2'b00, 3, 8'd7, 8'd7, 8'd3,
                     32'h1000_0100, 32'h1000_0120, 32'h1000_0140, 2'b00);
        vecs[2] = mk(1, 32'h2000_0000, 4'd9, 8'd15, 2'b01, 1, 2'b10, 2, 8'd7, 8'd7, 8'd0,
                     32'h2000_0000, 32'h2000_0020, 32'h0, 2'b10);
        vecs[3] = mk(0, 32'h3000_0010, 4'd1, 8'd15, 2'b00, -1, 2'b00, 1, 8'd15, 8'd0, 8'd0,
                     32'h3000_0010, 32'h0, 32'h0, 2'b00);
`ifdef SDRAM_SPLIT_BOUNDARY_EN
        vecs[4] = mk(0, 32'h0000_07F8, 4'd2, 8'd3, 2'b01, -1, 2'b00, 2, 8'd1, 8'd1, 8'd0,
                     32'h0000_07F8, 32'h0000_0800, 32'h0, 2'b00);
`else
        vecs[4] = mk(0, 32'h0000_07F8, 4'd2, 8'd3, 2'b01, -1, 2'b00, 1, 8'd3, 8'd0, 8'd0,
                     32'h0000_07F8, 32'h0, 32'h0, 2'b00);
`endif
        vecs[5] = mk(1, 32'h4000_0000, 4'd6, 8'd7, 2'b01, -1, 2'b00, 1, 8'd7, 8'd0, 8'd0,
                     32'h4000_0000, 32'h0, 32'h0, 2'b00);
        vecs[6] = mk(1, 32'h5000_0040, 4'd7, 8'd15, 2'b10, -1, 2'b00, 1, 8'd15, 8'd0, 8'd0,
                     32'h5000_0040, 32'h0, 32'h0, 2'b00);
        vecs[7] = mk(0, 32'hFFFF_FFFC, 4'd8, 8'd0, 2'b01, -1, 2'b00, 1, 8'd0, 8'd0, 8'd0,
                     32'hFFFF_FFFC, 32'h0, 32'h0, 2'b00);
        vecs[8] = mk(1, 32'hFFFF_FFE0, 4'd15, 8'd15, 2'b01, 0, 2'b11, 2, 8'd7, 8'd7, 8'd0,
                     32'hFFFF_FFE0, 32'h0000_0000, 32'h0, 2'b11);
        vecs[9] = mk(0, 32'h6000_0000, 4'd4, 8'd8, 2'b01, -1, 2'b00, 2, 8'd7, 8'd0, 8'd0,
                     32'h6000_0000, 32'h6000_0020, 32'h0, 2'b00);

        repeat (3) @(negedge clk_i);
        #1;
        check_all_idle("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // AW and AR presented together straight out of reset must both be taken in one cycle.
        fork
            run_write(vecs[0], -1);
            run_read(vecs[1]);
        join
        chk("aw_ar_same_cycle", 32'(t_aw), 32'(t_ar));

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) run_write(vecs[i], -1);
            else            run_read(vecs[i]);
        end

        // Reset while the 10th beat of a 20-beat write is offered, then a clean write.
        run_write(vecs[0], 9);
        s_awvalid_i = 0; s_wvalid_i = 0; m_awready_i = 0; m_wready_i = 0;
        m_bvalid_i = 0; s_bready_i = 0;
        repeat (2) @(negedge clk_i);
        #1;
        check_all_idle("in_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        run_write(vecs[0], -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
